// File: rtl/mux_sel_serializer_if.sv
// Byte-in / bit-select-out bus between an upstream byte source and the serializer.
//   load_valid, din, hold : driven by the upstream (master)
//   load_ready            : serializer can take a byte this cycle
//   sel, a, bit_valid     : current select index and selected bit
//   busy, done            : transfer in progress / one-cycle completion pulse
interface mux_sel_serializer_if;
    logic       load_valid;
    logic [7:0] din;
    logic       hold;
    logic       load_ready;
    logic [2:0] sel;
    logic       a;
    logic       bit_valid;
    logic       busy;
    logic       done;

    modport master (
        output load_valid, din, hold,
        input  load_ready, sel, a, bit_valid, busy, done
    );

    modport slave (
        input  load_valid, din, hold,
        output load_ready, sel, a, bit_valid, busy, done
    );
endinterface

// File: rtl/mux_sel_serializer.sv
// Captures a byte on a valid/ready handshake and walks a 3-bit select index
// across it, one bit per cycle, presenting the selected bit alongside the index.
//   clk        : single clock, rising edge
//   rst        : asynchronous active-high reset
//   bus.slave  : load_valid/din/hold in; load_ready/sel/a/bit_valid/busy/done out
// LSB_FIRST = 1 walks sel 0..7, LSB_FIRST = 0 walks sel 7..0.
module mux_sel_serializer #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    mux_sel_serializer_if.slave  bus
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned SEL_W  = 3;

    localparam logic [SEL_W-1:0] FIRST_IDX = LSB_FIRST ? SEL_W'(0) : SEL_W'(DATA_W - 1);
    localparam logic [SEL_W-1:0] LAST_IDX  = LSB_FIRST ? SEL_W'(DATA_W - 1) : SEL_W'(0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [DATA_W-1:0]   cap_q, cap_d;
    logic                load_ready_q, load_ready_d;
    logic                bit_valid_q, bit_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                a_q, a_d;

    // State, datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sel_q        <= FIRST_IDX;
            cap_q        <= '0;
            load_ready_q <= 1'b1;
            bit_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            a_q          <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            cap_q        <= cap_d;
            load_ready_q <= load_ready_d;
            bit_valid_q  <= bit_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            a_q          <= a_d;
        end
    end

    // Next state, next select index and next output values
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cap_d   = cap_q;

        case (state_q)
            IDLE: begin
                sel_d = FIRST_IDX;
                if (bus.load_valid && load_ready_q) begin
                    state_d = SHIFT;
                    cap_d   = bus.din;
                end
            end
            SHIFT: begin
                // hold freezes both sel and the captured byte
                if (!bus.hold) begin
                    if (sel_q == LAST_IDX) begin
                        state_d = DONE;
                    end else if (LSB_FIRST) begin
                        sel_d = sel_q + SEL_W'(1);
                    end else begin
                        sel_d = sel_q - SEL_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                sel_d   = FIRST_IDX;
            end
            default: begin
                state_d = IDLE;
                sel_d   = FIRST_IDX;
            end
        endcase

        // Outputs are registered from the next-state values so they line up
        // with the state they describe.
        load_ready_d = (state_d == IDLE);
        bit_valid_d  = (state_d == SHIFT);
        busy_d       = (state_d == SHIFT) || (state_d == DONE);
        done_d       = (state_d == DONE);
        a_d          = cap_d[sel_d];
    end

    assign bus.load_ready = load_ready_q;
    assign bus.bit_valid  = bit_valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.sel        = sel_q;
    assign bus.a          = a_q;

endmodule
